// File: rtl/rd_active_vertex_edge_single_if.sv
// Edge-read request bus between the active-vertex edge splitter and the
// edge-memory read stage. The splitter drives it through the master modport.
// The consumer drives next_stage_full back through the slave modport.
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef V_OFF_DWIDTH
`define V_OFF_DWIDTH 32
`endif
`ifndef V_VALUE_WIDTH
`define V_VALUE_WIDTH 32
`endif

interface rd_active_vertex_edge_single_if #(
  parameter int V_ID_WIDTH      = `V_ID_WIDTH,
  parameter int V_OFF_DWIDTH    = `V_OFF_DWIDTH,
  parameter int V_VALUE_WIDTH   = `V_VALUE_WIDTH,
  parameter int BURST_LEN_WIDTH = 4
);
  logic [V_OFF_DWIDTH-1:0]    rd_edge_addr;
  logic [BURST_LEN_WIDTH-1:0] rd_edge_len;
  logic [V_ID_WIDTH-1:0]      rd_edge_v_id;
  logic [V_VALUE_WIDTH-1:0]   rd_edge_v_value;
  logic                       rd_edge_last;
  logic                       rd_edge_valid;
  logic                       next_stage_full;

  modport master (
    output rd_edge_addr, rd_edge_len, rd_edge_v_id, rd_edge_v_value,
           rd_edge_last, rd_edge_valid,
    input  next_stage_full
  );

  modport slave (
    input  rd_edge_addr, rd_edge_len, rd_edge_v_id, rd_edge_v_value,
           rd_edge_last, rd_edge_valid,
    output next_stage_full
  );
endinterface

// File: rtl/rd_active_vertex_edge_single.sv
// Active-vertex edge splitter: buffers {vertex, offsets, value} pushed by the
// offset/value read stage and cuts each edge range [start, end) into burst
// requests of at most BURST_MAX edges. The iteration-end marker is forwarded
// only once all work has drained.
// Optional macro EDGE_BURST_ALIGN_EN: clip the first burst of a vertex so that
// all later bursts start on a BURST_MAX boundary.
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef V_OFF_DWIDTH
`define V_OFF_DWIDTH 32
`endif
`ifndef V_VALUE_WIDTH
`define V_VALUE_WIDTH 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif

module rd_active_vertex_edge_single #(
  parameter int V_ID_WIDTH      = `V_ID_WIDTH,
  parameter int V_OFF_DWIDTH    = `V_OFF_DWIDTH,
  parameter int V_VALUE_WIDTH   = `V_VALUE_WIDTH,
  parameter int ITERATION_WIDTH = `ITERATION_WIDTH,
  parameter int BURST_MAX       = 8,
  parameter int BURST_LEN_WIDTH = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_PFULL      = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [V_ID_WIDTH-1:0]        front_active_v_id,
  input  logic                         front_active_v_valid,
  input  logic [2*V_OFF_DWIDTH-1:0]    front_active_v_offset,
  input  logic [V_VALUE_WIDTH-1:0]     front_active_v_value,
  input  logic                         front_iteration_end,
  input  logic                         front_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0]   front_iteration_id,
  output logic                         stage_full,
  output logic                         iteration_end,
  output logic                         iteration_end_valid,
  output logic [ITERATION_WIDTH-1:0]   iteration_id,
  rd_active_vertex_edge_single_if.master req
);
  localparam int ENTRY_W = V_ID_WIDTH + 2*V_OFF_DWIDTH + V_VALUE_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ALIGN_W = $clog2(BURST_MAX);
  localparam logic [PTR_W:0]        DEPTH_C     = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]        PFULL_C     = (PTR_W+1)'(FIFO_PFULL);
  localparam logic [V_OFF_DWIDTH:0] BURST_MAX_W = (V_OFF_DWIDTH+1)'(BURST_MAX);

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;

  // vertex buffer: entries packed as {id, end, start, value}
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_next;
  logic               overflow;
  logic               push_ok, push_drop, pop;

  logic [ENTRY_W-1:0]       head;
  logic [V_ID_WIDTH-1:0]    head_id;
  logic [V_OFF_DWIDTH-1:0]  head_start, head_end;
  logic [V_VALUE_WIDTH-1:0] head_value;

  // vertex currently being split
  logic [V_OFF_DWIDTH-1:0]  cur_addr, end_r;
  logic [V_ID_WIDTH-1:0]    cur_id;
  logic [V_VALUE_WIDTH-1:0] cur_value;

  logic [V_OFF_DWIDTH:0] remaining, room, blen_wide;
  logic                  is_last;

  assign push_ok    = front_active_v_valid && (count != DEPTH_C);
  assign push_drop  = front_active_v_valid && (count == DEPTH_C);
  assign pop        = (state == IDLE) && (count != '0);
  assign count_next = count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};

  assign head       = mem[rd_ptr];
  assign head_id    = head[ENTRY_W-1 -: V_ID_WIDTH];
  assign head_end   = head[V_VALUE_WIDTH+V_OFF_DWIDTH +: V_OFF_DWIDTH];
  assign head_start = head[V_VALUE_WIDTH +: V_OFF_DWIDTH];
  assign head_value = head[V_VALUE_WIDTH-1:0];

  // one extra bit so a corrupt range can never wrap into a huge length
  assign remaining = {1'b0, end_r} - {1'b0, cur_addr};
`ifdef EDGE_BURST_ALIGN_EN
  assign room = BURST_MAX_W - {{(V_OFF_DWIDTH+1-ALIGN_W){1'b0}}, cur_addr[ALIGN_W-1:0]};
`else
  assign room = BURST_MAX_W;
`endif
  assign blen_wide = (remaining < room) ? remaining : room;
  assign is_last   = (blen_wide == remaining);

  // buffer storage write port, no reset needed on the data itself
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {front_active_v_id, front_active_v_offset, front_active_v_value};
  end

  // buffer pointers, occupancy, backpressure and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      stage_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      overflow   <= overflow | push_drop;
      stage_full <= (count_next >= PFULL_C);
    end
  end

  // pop a vertex in IDLE, then emit one burst per unstalled cycle in ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cur_addr            <= '0;
      end_r               <= '0;
      cur_id              <= '0;
      cur_value           <= '0;
      req.rd_edge_valid   <= 1'b0;
      req.rd_edge_addr    <= '0;
      req.rd_edge_len     <= '0;
      req.rd_edge_v_id    <= '0;
      req.rd_edge_v_value <= '0;
      req.rd_edge_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req.rd_edge_valid <= 1'b0;
          req.rd_edge_last  <= 1'b0;
          if (pop) begin
            cur_addr  <= head_start;
            end_r     <= head_end;
            cur_id    <= head_id;
            cur_value <= head_value;
            // empty or inverted ranges are consumed without a request
            if (head_start < head_end) state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!req.next_stage_full) begin
            req.rd_edge_valid   <= 1'b1;
            req.rd_edge_addr    <= cur_addr;
            req.rd_edge_len     <= blen_wide[BURST_LEN_WIDTH-1:0];
            req.rd_edge_v_id    <= cur_id;
            req.rd_edge_v_value <= cur_value;
            req.rd_edge_last    <= is_last;
            cur_addr            <= cur_addr + blen_wide[V_OFF_DWIDTH-1:0];
            if (is_last) state <= IDLE;
          end else begin
            req.rd_edge_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // iteration id pass-through and end marker once fully drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iteration_id        <= '0;
      iteration_end       <= 1'b0;
      iteration_end_valid <= 1'b0;
    end else begin
      iteration_id <= front_iteration_id;
      iteration_end <= front_iteration_end && front_iteration_end_valid &&
                       (count == '0) && (state == IDLE) && !front_active_v_valid;
      iteration_end_valid <= front_iteration_end && front_iteration_end_valid &&
                             (count == '0) && (state == IDLE) && !front_active_v_valid;
    end
  end
endmodule

// File: tb/tb_rd_active_vertex_edge_single.sv
// Directed bench for rd_active_vertex_edge_single: burst splitting, zero-degree
// drop, backpressure/occupancy, stall, iteration-end drain and async reset.
module tb_rd_active_vertex_edge_single;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] front_active_v_id = '0;
  logic        front_active_v_valid = 1'b0;
  logic [63:0] front_active_v_offset = '0;
  logic [31:0] front_active_v_value = '0;
  logic        front_iteration_end = 1'b0;
  logic        front_iteration_end_valid = 1'b0;
  logic [7:0]  front_iteration_id = '0;
  logic        stage_full, iteration_end, iteration_end_valid;
  logic [7:0]  iteration_id;

  int compared = 0;
  int mismatched = 0;

  rd_active_vertex_edge_single_if #(.V_ID_WIDTH(32), .V_OFF_DWIDTH(32),
    .V_VALUE_WIDTH(32), .BURST_LEN_WIDTH(4)) req_if ();

  rd_active_vertex_edge_single #(.V_ID_WIDTH(32), .V_OFF_DWIDTH(32),
    .V_VALUE_WIDTH(32), .ITERATION_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .front_active_v_id(front_active_v_id),
    .front_active_v_valid(front_active_v_valid),
    .front_active_v_offset(front_active_v_offset),
    .front_active_v_value(front_active_v_value),
    .front_iteration_end(front_iteration_end),
    .front_iteration_end_valid(front_iteration_end_valid),
    .front_iteration_id(front_iteration_id),
    .stage_full(stage_full),
    .iteration_end(iteration_end),
    .iteration_end_valid(iteration_end_valid),
    .iteration_id(iteration_id),
    .req(req_if.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a,
                         input logic [3:0] l, input logic last, input logic [31:0] id,
                         input logic [31:0] val);
    chk({tag, ".valid"}, 64'(req_if.rd_edge_valid), 64'(v));
    if (v) begin
      chk({tag, ".addr"},  64'(req_if.rd_edge_addr), 64'(a));
      chk({tag, ".len"},   64'(req_if.rd_edge_len), 64'(l));
      chk({tag, ".last"},  64'(req_if.rd_edge_last), 64'(last));
      chk({tag, ".v_id"},  64'(req_if.rd_edge_v_id), 64'(id));
      chk({tag, ".value"}, 64'(req_if.rd_edge_v_value), 64'(val));
    end
    $display("txn %s valid=%0b addr=%0d len=%0d last=%0b id=%0d", tag,
             req_if.rd_edge_valid, req_if.rd_edge_addr, req_if.rd_edge_len,
             req_if.rd_edge_last, req_if.rd_edge_v_id);
  endtask

  task automatic push(input logic [31:0] id, input logic [31:0] st,
                      input logic [31:0] en, input logic [31:0] val);
    front_active_v_id     = id;
    front_active_v_offset = {en, st};
    front_active_v_value  = val;
    front_active_v_valid  = 1'b1;
  endtask

  initial begin
    int seen;
    req_if.next_stage_full = 1'b0;

    // reset state
    rst = 1'b1;
    step(); step();
    chk("rst.valid", 64'(req_if.rd_edge_valid), 64'd0);
    chk("rst.stage_full", 64'(stage_full), 64'd0);
    chk("rst.iev", 64'(iteration_end_valid), 64'd0);
    chk("rst.iter_id", 64'(iteration_id), 64'd0);
    rst = 1'b0;
    step();

    // v=5 {20,3} value 7
    push(32'd5, 32'd3, 32'd20, 32'd7);
    step();
    front_active_v_valid = 1'b0;
    step();
    chk_req("t1.pop", 1'b0, 0, 0, 0, 0, 0);
    step();
`ifdef EDGE_BURST_ALIGN_EN
    chk_req("t1.b0", 1'b1, 32'd3, 4'd5, 1'b0, 32'd5, 32'd7);
    step();
    chk_req("t1.b1", 1'b1, 32'd8, 4'd8, 1'b0, 32'd5, 32'd7);
    step();
    chk_req("t1.b2", 1'b1, 32'd16, 4'd4, 1'b1, 32'd5, 32'd7);
`else
    chk_req("t1.b0", 1'b1, 32'd3, 4'd8, 1'b0, 32'd5, 32'd7);
    step();
    chk_req("t1.b1", 1'b1, 32'd11, 4'd8, 1'b0, 32'd5, 32'd7);
    step();
    chk_req("t1.b2", 1'b1, 32'd19, 4'd1, 1'b1, 32'd5, 32'd7);
`endif
    step();
    chk_req("t1.done", 1'b0, 0, 0, 0, 0, 0);

    // v=9 with start=end=40: dropped; end marker proves empty and idle
    push(32'd9, 32'd40, 32'd40, 32'd1);
    step();
    front_active_v_valid = 1'b0;
    front_iteration_end = 1'b1;
    front_iteration_end_valid = 1'b1;
    step();
    chk_req("t2.c1", 1'b0, 0, 0, 0, 0, 0);
    chk("t2.iev_busy", 64'(iteration_end_valid), 64'd0);
    step();
    chk_req("t2.c2", 1'b0, 0, 0, 0, 0, 0);
    chk("t2.iev_empty", 64'(iteration_end_valid), 64'd1);
    front_iteration_end = 1'b0;
    front_iteration_end_valid = 1'b0;
    step();
    chk_req("t2.c3", 1'b0, 0, 0, 0, 0, 0);

    // 14 back-to-back pushes while stalled; first is already popped
    req_if.next_stage_full = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push(32'(100 + i), 32'(16 * i), 32'(16 * i + 2), 32'(i));
      step();
      if (i == 11) chk("t3.sf_after12", 64'(stage_full), 64'd0);
      if (i == 12) chk("t3.sf_after13", 64'(stage_full), 64'd1);
    end
    front_active_v_valid = 1'b0;
    chk("t3.sf_after14", 64'(stage_full), 64'd1);
    chk("t3.stalled", 64'(req_if.rd_edge_valid), 64'd0);
    req_if.next_stage_full = 1'b0;
    for (int k = 0; k < 14; k++) begin
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
        step();
        if (req_if.rd_edge_valid) seen = 1;
      end
      chk($sformatf("t3.v%0d.seen", k), 64'(seen), 64'd1);
      if (seen != 0) chk_req($sformatf("t3.v%0d", k), 1'b1, 32'(16 * k), 4'd2, 1'b1,
                             32'(100 + k), 32'(k));
    end
    step(); step();
    chk("t3.sf_drained", 64'(stage_full), 64'd0);
    chk_req("t3.idle", 1'b0, 0, 0, 0, 0, 0);

    // stall 3 cycles mid-vertex, v=3 {24,0}
    push(32'd3, 32'd0, 32'd24, 32'd1);
    step();
    front_active_v_valid = 1'b0;
    step();
    step();
    chk_req("t4.b0", 1'b1, 32'd0, 4'd8, 1'b0, 32'd3, 32'd1);
    req_if.next_stage_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("t4.stall%0d.valid", s), 64'(req_if.rd_edge_valid), 64'd0);
      chk($sformatf("t4.stall%0d.addr", s), 64'(req_if.rd_edge_addr), 64'd0);
    end
    req_if.next_stage_full = 1'b0;
    step();
    chk_req("t4.b1", 1'b1, 32'd8, 4'd8, 1'b0, 32'd3, 32'd1);
    step();
    chk_req("t4.b2", 1'b1, 32'd16, 4'd8, 1'b1, 32'd3, 32'd1);
    step();
    chk_req("t4.done", 1'b0, 0, 0, 0, 0, 0);

    // end marker held while two degree-8 vertices drain
    front_iteration_end = 1'b1;
    front_iteration_end_valid = 1'b1;
    front_iteration_id = 8'h5A;
    push(32'd20, 32'd32, 32'd40, 32'd2);
    step();
    chk("t5.iev0", 64'(iteration_end_valid), 64'd0);
    chk("t5.iter_id", 64'(iteration_id), 64'h5A);
    push(32'd21, 32'd48, 32'd56, 32'd3);
    step();
    front_active_v_valid = 1'b0;
    chk("t5.iev1", 64'(iteration_end_valid), 64'd0);
    step();
    chk_req("t5.v20", 1'b1, 32'd32, 4'd8, 1'b1, 32'd20, 32'd2);
    chk("t5.iev2", 64'(iteration_end_valid), 64'd0);
    step();
    chk("t5.iev3", 64'(iteration_end_valid), 64'd0);
    step();
    chk_req("t5.v21", 1'b1, 32'd48, 4'd8, 1'b1, 32'd21, 32'd3);
    chk("t5.iev4", 64'(iteration_end_valid), 64'd0);
    step();
    chk("t5.iev5", 64'(iteration_end_valid), 64'd1);
    chk("t5.ie5", 64'(iteration_end), 64'd1);
    front_iteration_end = 1'b0;
    front_iteration_end_valid = 1'b0;
    step();
    chk("t5.iev_off", 64'(iteration_end_valid), 64'd0);

    // async reset during the second burst of v=30 {20,0}, v=31 queued
    push(32'd30, 32'd0, 32'd20, 32'd4);
    step();
    push(32'd31, 32'd64, 32'd80, 32'd5);
    step();
    front_active_v_valid = 1'b0;
    step();
    chk_req("t6.b0", 1'b1, 32'd0, 4'd8, 1'b0, 32'd30, 32'd4);
    step();
    chk_req("t6.b1", 1'b1, 32'd8, 4'd8, 1'b0, 32'd30, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.rst.valid", 64'(req_if.rd_edge_valid), 64'd0);
    chk("t6.rst.addr", 64'(req_if.rd_edge_addr), 64'd0);
    chk("t6.rst.len", 64'(req_if.rd_edge_len), 64'd0);
    chk("t6.rst.v_id", 64'(req_if.rd_edge_v_id), 64'd0);
    chk("t6.rst.value", 64'(req_if.rd_edge_v_value), 64'd0);
    chk("t6.rst.iter_id", 64'(iteration_id), 64'd0);
    chk("t6.rst.sf", 64'(stage_full), 64'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("t6.post%0d", c), 64'(req_if.rd_edge_valid), 64'd0);
    end
    chk("t6.post.sf", 64'(stage_full), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
